ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 25, word address width shared by both ports and the memory side.
REQ-002 Parameter: DATA_W, 16, data word width.
REQ-003 Parameter: RD_TIMEOUT, 255, maximum cycles spent waiting for read data before abort.
REQ-004 Port: clk50  in  1  sole clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: boot_lock  in  1  when high, only port 0 (SD init loader) may be granted.
REQ-007 Port: p_req  in  [1:0]  per-port request, held until accepted.
REQ-008 Port: p_we  in  [1:0]  per-port write (1) / read (0).
REQ-009 Port: p0_addr, p1_addr  in  ADDR_W each  per-port word address.
REQ-010 Port: p0_wdata, p1_wdata  in  DATA_W each  per-port write data.
REQ-011 Port: p_op_begun  out  [1:0]  one-cycle accept pulse to the granted port.
REQ-012 Port: p_rdata  out  DATA_W  read data, common to both ports.
REQ-013 Port: p_rvalid  out  [1:0]  one-cycle read-data-valid pulse to the requesting port.
REQ-014 Port: mem_req, mem_we  out  1 each  memory-controller command request and direction.
REQ-015 Port: mem_addr / mem_wdata  out  ADDR_W / DATA_W  command address and write data.
REQ-016 Port: mem_op_begun, mem_rvalid  in  1 each  controller accept pulse and read-data strobe.
REQ-017 Port: mem_rdata  in  DATA_W  controller read data.
REQ-018 Port: grant  out  [1:0]  one-hot current owner; 0 when idle.
REQ-019 Port: rd_timeout  out  1  sticky read-timeout error flag.

Function
REQ-020 FSM states: IDLE, ISSUE, RD_WAIT.
REQ-021 IDLE: eligible = p_req, with bit 1 masked while boot_lock=1; if any port is eligible, register grant and go to ISSUE, so mem_req rises one cycle after p_req is sampled.
REQ-022 Both ports eligible: grant the port that was not granted last (round-robin); last_grant resets to 1, so port 0 wins the first tie.
REQ-023 ISSUE: mem_req=1 and mem_we/mem_addr/mem_wdata are passed through from the granted port; p_op_begun[g] = mem_op_begun, combinationally.
REQ-024 ISSUE with mem_op_begun: a write goes to IDLE; a read goes to RD_WAIT and clears the timeout counter.
REQ-025 ISSUE with the granted p_req low before acceptance: abandon the request, mem_req=0 in that cycle, go to IDLE.
REQ-026 RD_WAIT: p_rvalid[g] = mem_rvalid and p_rdata = mem_rdata; on mem_rvalid go to IDLE; only one read is outstanding at a time.
REQ-027 RD_WAIT: an 8-bit counter increments each cycle; on reaching RD_TIMEOUT, pulse p_rvalid[g] with p_rdata=0, set rd_timeout, go to IDLE.
REQ-028 mem_rvalid in IDLE or ISSUE is ignored and never forwarded.
REQ-029 grant returns to 0 in the cycle the FSM re-enters IDLE; back-to-back grants have at least one IDLE cycle between them.
REQ-030 boot_lock rising during a port-1 transaction does not abort that transaction; the mask applies only at the next IDLE decision.
REQ-031 Outputs not named as active are 0; p_rdata = mem_rdata only in RD_WAIT, 0 otherwise.

Reset
REQ-032 On reset: state=IDLE, grant=0, last_grant=1, counter=0, rd_timeout=0; all mem_* and p_* outputs read 0 in the following cycle.
REQ-033 Reset mid-transaction drops mem_req immediately; late controller responses are discarded per REQ-028.

Structure
REQ-034 Package ram_arb_pkg holds the state enum, the ADDR_W/DATA_W defaults, and the port-index constants.
REQ-035 Sub-module arb_rr2 (2-way round-robin picker: eligible, last_grant -> one-hot pick) is the single natural child.

Verification
REQ-036 Port 0 write addr 0x000010, data 0xBEEF, mem_op_begun 2 cycles after mem_req -> mem_addr=0x000010, mem_wdata=0xBEEF, single p_op_begun[0] pulse, grant back to 0.
REQ-037 Both ports request writes simultaneously, boot_lock=0 -> order port 0, port 1, port 0; at least one IDLE cycle between grants.
REQ-038 boot_lock=1 with both requesting for 10 transactions -> port 1 never granted; boot_lock drops -> port 1 granted at the next IDLE.
REQ-039 Port 1 read at 0x1FFFFF, mem_rvalid after 5 cycles with 0x1234 -> p_rvalid[1] pulse with p_rdata=0x1234; p_rvalid[0] stays 0.
REQ-040 Read with mem_rvalid never asserted -> after 255 cycles p_rvalid pulses with data 0, rd_timeout=1 and stays set until reset.
REQ-041 Reset asserted in RD_WAIT, then mem_rvalid arrives -> mem_req=0, no p_rvalid pulse, grant=0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RD_WAIT
  } arb_state_e;

  localparam int unsigned ARB_ADDR_W = 25;
  localparam int unsigned ARB_DATA_W = 16;

  // Port 0 is the SD init loader, port 1 the general requester.
  localparam int unsigned PORT0 = 0;
  localparam int unsigned PORT1 = 1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: one-hot pick from eligible requests,
// favouring the port that did not win last time on a tie.
module arb_rr2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] pick
);

  always_comb begin
    pick = eligible;
    if (eligible == 2'b11) begin
      pick = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two word-addressed request ports onto one memory-controller
// command port, one transaction at a time, with a read-data timeout.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W,
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              boot_lock,
  input  logic [1:0]        p_req,
  input  logic [1:0]        p_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [1:0]        p_op_begun,
  output logic [DATA_W-1:0] p_rdata,
  output logic [1:0]        p_rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_op_begun,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              rd_timeout
);

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;

  logic [1:0]  eligible;
  logic [1:0]  pick;
  logic        gsel;
  logic        req_live;
  logic        timeout_hit;

  // boot_lock only masks new decisions; an owned transaction runs to completion.
  assign eligible    = p_req & {~boot_lock, 1'b1};
  assign gsel        = grant_q[PORT1];
  assign req_live    = p_req[gsel];
  assign timeout_hit = (cnt_q == 8'(RD_TIMEOUT - 1));

  arb_rr2 u_rr (
    .eligible   (eligible),
    .last_grant (last_q),
    .pick       (pick)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    p_op_begun = '0;
    p_rvalid   = '0;
    p_rdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (eligible != 2'b00) begin
          grant_d = pick;
          last_d  = pick[PORT1];
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (!req_live) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else begin
          mem_req    = 1'b1;
          mem_we     = p_we[gsel];
          mem_addr   = gsel ? p1_addr : p0_addr;
          mem_wdata  = gsel ? p1_wdata : p0_wdata;
          p_op_begun = grant_q & {2{mem_op_begun}};
          if (mem_op_begun) begin
            if (p_we[gsel]) begin
              state_d = ST_IDLE;
              grant_d = '0;
            end else begin
              state_d = ST_RD_WAIT;
              cnt_d   = '0;
            end
          end
        end
      end

      ST_RD_WAIT: begin
        p_rdata = mem_rdata;
        cnt_d   = cnt_q + 8'd1;
        if (mem_rvalid) begin
          p_rvalid = grant_q;
          state_d  = ST_IDLE;
          grant_d  = '0;
        end else if (timeout_hit) begin
          p_rvalid = grant_q;
          p_rdata  = '0;
          to_d     = 1'b1;
          state_d  = ST_IDLE;
          grant_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign grant      = grant_q;
  assign rd_timeout = to_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: requester and memory-controller
// models drive the DUT; expected commands/responses are queued up front.
module tb_ram_port_arbiter;

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [24:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct {
    logic [1:0]  port;
    logic [15:0] data;
  } rsp_t;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        boot_lock;
  logic [1:0]  p_req;
  logic [1:0]  p_we;
  logic [24:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [1:0]  p_op_begun;
  logic [15:0] p_rdata;
  logic [1:0]  p_rvalid;
  logic        mem_req, mem_we;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_op_begun, mem_rvalid;
  logic [15:0] mem_rdata;
  logic [1:0]  grant;
  logic        rd_timeout;

  ram_port_arbiter #(.ADDR_W(25), .DATA_W(16), .RD_TIMEOUT(255)) dut (
    .clk50(clk50), .reset(reset), .boot_lock(boot_lock),
    .p_req(p_req), .p_we(p_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p_op_begun(p_op_begun), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_op_begun(mem_op_begun), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .grant(grant), .rd_timeout(rd_timeout)
  );

  always #10 clk50 = ~clk50;

  cmd_t        exp_q[$];
  rsp_t        rsp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          acc_lat, rd_lat, acc_cnt, rd_cnt;
  bit          rd_never, rd_pend, done_prev;
  logic [15:0] rd_data;
  logic [1:0]  drop_mask;
  int          rem[2];
  int          begun_cnt[2];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rv_delay = 0;
  int          gap_viol, lock_viol;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic push_cmd(input logic [1:0] port, input logic we,
                          input logic [24:0] addr, input logic [15:0] wdata);
    cmd_t c;
    c.port = port; c.we = we; c.addr = addr; c.wdata = wdata;
    exp_q.push_back(c);
  endtask

  task automatic push_rsp(input logic [1:0] port, input logic [15:0] data);
    rsp_t r;
    r.port = port; r.data = data;
    rsp_q.push_back(r);
  endtask

  task automatic do_reset();
    reset = 1'b1; boot_lock = 1'b0; p_req = '0; p_we = '0;
    mem_op_begun = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_q.delete(); rsp_q.delete();
    acc_lat = 0; rd_lat = 1; rd_never = 1'b0; rd_data = '0;
    acc_cnt = 0; rd_cnt = 0; rd_pend = 1'b0; done_prev = 1'b0; drop_mask = '0;
    rem[0] = 0; rem[1] = 0; begun_cnt[0] = 0; begun_cnt[1] = 0;
    gap_viol = 0; lock_viol = 0;
    repeat (2) @(posedge clk50);
    #2 reset = 1'b0;
  endtask

  // One clock of requester + controller models, then scoreboard checks.
  task automatic step();
    cmd_t e;
    rsp_t r;
    int   p;
    @(posedge clk50); #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (drop_mask[i]) begin
        if (rem[i] <= 0) p_req[i] = 1'b0;
        else if (i == 0) p0_wdata = p0_wdata + 16'd1;
        else p1_wdata = p1_wdata + 16'd1;
      end
    end
    drop_mask = '0;
    mem_op_begun = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    if (rd_pend) begin
      rd_cnt++;
      if (rd_never) mem_rdata = 16'hDEAD;
      else if (rd_cnt >= rd_lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_data;
      end
    end else if (mem_req) begin
      if (acc_cnt >= acc_lat) begin
        mem_op_begun = 1'b1;
        acc_cnt = 0;
      end else acc_cnt++;
    end else acc_cnt = 0;
    #1;
    if (done_prev && grant !== 2'b00) gap_viol++;
    if (boot_lock && grant[1] === 1'b1) lock_viol++;
    done_prev = 1'b0;
    if (p_op_begun !== 2'b00) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL accept_unexpected: p_op_begun=%b, required no accept", p_op_begun);
      end else begin
        e = exp_q.pop_front();
        if (p_op_begun !== e.port || grant !== e.port || mem_we !== e.we ||
            mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
          fails++;
          $display("FAIL accept: begun=%b grant=%b we=%b addr=%h wdata=%h, required port=%b we=%b addr=%h wdata=%h",
                   p_op_begun, grant, mem_we, mem_addr, mem_wdata, e.port, e.we, e.addr, e.wdata);
        end
      end
      p = p_op_begun[1] ? 1 : 0;
      begun_cnt[p]++;
      rem[p]--;
      drop_mask = p_op_begun;
      if (mem_we) done_prev = 1'b1;
      else begin
        rd_pend = 1'b1;
        rd_cnt  = 0;
        acc_cyc = cyc;
      end
    end
    if (p_rvalid !== 2'b00) begin
      tests++;
      if (rsp_q.size() == 0) begin
        fails++;
        $display("FAIL rvalid_unexpected: p_rvalid=%b p_rdata=%h, required no pulse", p_rvalid, p_rdata);
      end else begin
        r = rsp_q.pop_front();
        if (p_rvalid !== r.port || p_rdata !== r.data) begin
          fails++;
          $display("FAIL rvalid: p_rvalid=%b p_rdata=%h, required %b / %h", p_rvalid, p_rdata, r.port, r.data);
        end
      end
      rv_delay  = cyc - acc_cyc;
      rd_pend   = 1'b0;
      done_prev = 1'b1;
    end
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    bit busy;
    busy = 1'b1;
    while (busy && n < budget) begin
      step();
      n++;
      busy = (exp_q.size() != 0) || (rsp_q.size() != 0) || rd_pend || (p_req != 2'b00);
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s_done: still busy after %0d cycles, required idle", name, n);
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, required all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    tests++;
    if (p_op_begun !== 2'b00 || p_rvalid !== 2'b00 || p_rdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_port: begun=%b rvalid=%b rdata=%h, required all 0", p_op_begun, p_rvalid, p_rdata);
    end
    tests++;
    if (grant !== 2'b00 || rd_timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: grant=%b rd_timeout=%b, required 00 / 0", grant, rd_timeout);
    end
  endtask

  task automatic test_write();
    acc_lat = 2;
    p_we[0] = 1'b1; p0_addr = 25'h000010; p0_wdata = 16'hBEEF;
    p_req[0] = 1'b1; rem[0] = 1;
    push_cmd(2'b01, 1'b1, 25'h000010, 16'hBEEF);
    step();
    tests++;
    if (mem_req !== 1'b1 || grant !== 2'b01) begin
      fails++;
      $display("FAIL write_latency: mem_req=%b grant=%b, required 1 / 01", mem_req, grant);
    end
    run_until_idle(50, "write");
    tests++;
    if (begun_cnt[0] !== 1 || begun_cnt[1] !== 0) begin
      fails++;
      $display("FAIL write_pulses: begun0=%0d begun1=%0d, required 1 / 0", begun_cnt[0], begun_cnt[1]);
    end
    tests++;
    if (grant !== 2'b00 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL write_release: grant=%b mem_req=%b, required 00 / 0", grant, mem_req);
    end
  endtask

  task automatic test_read();
    acc_lat = 1; rd_lat = 5; rd_data = 16'h1234;
    p_we[1] = 1'b0; p1_addr = 25'h1FFFFF; p1_wdata = 16'h0;
    p_req[1] = 1'b1; rem[1] = 1;
    push_cmd(2'b10, 1'b0, 25'h1FFFFF, 16'h0);
    push_rsp(2'b10, 16'h1234);
    run_until_idle(50, "read");
    tests++;
    if (rv_delay !== 5) begin
      fails++;
      $display("FAIL read_latency: %0d cycles accept->rvalid, required 5", rv_delay);
    end
  endtask

  task automatic test_stray_rvalid();
    mem_rvalid = 1'b1; mem_rdata = 16'h7777;
    #1;
    tests++;
    if (p_rvalid !== 2'b00 || p_rdata !== 16'h0) begin
      fails++;
      $display("FAIL stray_idle: p_rvalid=%b p_rdata=%h, required 00 / 0000", p_rvalid, p_rdata);
    end
    mem_rvalid = 1'b0; mem_rdata = '0;
    acc_lat = 3; rd_lat = 2; rd_data = 16'h4321;
    p_we[0] = 1'b0; p0_addr = 25'h0000AB; p_req[0] = 1'b1; rem[0] = 1;
    push_cmd(2'b01, 1'b0, 25'h0000AB, 16'h0);
    push_rsp(2'b01, 16'h4321);
    step();
    mem_rvalid = 1'b1; mem_rdata = 16'h7777;
    #1;
    tests++;
    if (mem_req !== 1'b1 || p_rvalid !== 2'b00 || p_rdata !== 16'h0) begin
      fails++;
      $display("FAIL stray_issue: mem_req=%b p_rvalid=%b p_rdata=%h, required 1 / 00 / 0000", mem_req, p_rvalid, p_rdata);
    end
    mem_rvalid = 1'b0; mem_rdata = '0;
    run_until_idle(50, "stray");
  endtask

  task automatic test_abandon();
    acc_lat = 50;
    p_we[0] = 1'b1; p0_addr = 25'h000055; p_req[0] = 1'b1; rem[0] = 1;
    step();
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL abandon_issue: mem_req=%b, required 1", mem_req);
    end
    p_req[0] = 1'b0; rem[0] = 0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || p_op_begun !== 2'b00) begin
      fails++;
      $display("FAIL abandon_drop: mem_req=%b begun=%b, required 0 / 00", mem_req, p_op_begun);
    end
    step();
    tests++;
    if (grant !== 2'b00 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL abandon_idle: grant=%b mem_req=%b, required 00 / 0", grant, mem_req);
    end
    acc_lat = 0;
  endtask

  task automatic test_round_robin();
    do_reset();
    acc_lat = 1;
    p_we = 2'b11;
    p0_addr = 25'h000100; p0_wdata = 16'hA000; rem[0] = 2;
    p1_addr = 25'h000200; p1_wdata = 16'hB000; rem[1] = 1;
    push_cmd(2'b01, 1'b1, 25'h000100, 16'hA000);
    push_cmd(2'b10, 1'b1, 25'h000200, 16'hB000);
    push_cmd(2'b01, 1'b1, 25'h000100, 16'hA001);
    p_req = 2'b11;
    run_until_idle(100, "round_robin");
    tests++;
    if (gap_viol !== 0) begin
      fails++;
      $display("FAIL rr_idle_gap: %0d grants without idle cycle, required 0", gap_viol);
    end
  endtask

  task automatic test_boot_lock();
    int n = 0;
    do_reset();
    boot_lock = 1'b1;
    p_we = 2'b11;
    p0_addr = 25'h000010; p0_wdata = 16'hC000; rem[0] = 10;
    p1_addr = 25'h000020; p1_wdata = 16'hD000; rem[1] = 1;
    for (int i = 0; i < 10; i++) push_cmd(2'b01, 1'b1, 25'h000010, 16'hC000 + 16'(i));
    push_cmd(2'b10, 1'b1, 25'h000020, 16'hD000);
    p_req = 2'b11;
    while (exp_q.size() > 1 && n < 400) begin
      step();
      n++;
    end
    boot_lock = 1'b0;
    repeat (2) step();
    tests++;
    if (grant !== 2'b10) begin
      fails++;
      $display("FAIL lock_release: grant=%b, required 10", grant);
    end
    run_until_idle(50, "boot_lock");
    tests++;
    if (lock_viol !== 0 || gap_viol !== 0) begin
      fails++;
      $display("FAIL lock_mask: port1 cycles under lock=%0d idle gaps=%0d, required 0 / 0", lock_viol, gap_viol);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    rd_never = 1'b1;
    p_we[0] = 1'b0; p0_addr = 25'h000123; p_req[0] = 1'b1; rem[0] = 1;
    push_cmd(2'b01, 1'b0, 25'h000123, 16'h0);
    push_rsp(2'b01, 16'h0000);
    run_until_idle(400, "timeout");
    tests++;
    if (rv_delay !== 255 || rd_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout: %0d cycles rd_timeout=%b, required 255 / 1", rv_delay, rd_timeout);
    end
    rd_never = 1'b0;
    p_we[1] = 1'b1; p1_addr = 25'h000321; p1_wdata = 16'h5A5A; p_req[1] = 1'b1; rem[1] = 1;
    push_cmd(2'b10, 1'b1, 25'h000321, 16'h5A5A);
    run_until_idle(50, "after_timeout");
    tests++;
    if (rd_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_sticky: rd_timeout=%b, required 1", rd_timeout);
    end
    do_reset();
    tests++;
    if (rd_timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: rd_timeout=%b, required 0", rd_timeout);
    end
  endtask

  task automatic test_reset_in_rd_wait();
    int n = 0;
    do_reset();
    rd_never = 1'b1;
    p_we[1] = 1'b0; p1_addr = 25'h0ABCDE; p_req[1] = 1'b1; rem[1] = 1;
    push_cmd(2'b10, 1'b0, 25'h0ABCDE, 16'h0);
    while (!rd_pend && n < 20) begin
      step();
      n++;
    end
    repeat (3) step();
    tests++;
    if (grant !== 2'b10 || rd_pend !== 1'b1) begin
      fails++;
      $display("FAIL rst_rdwait_setup: grant=%b pending=%b, required 10 / 1", grant, rd_pend);
    end
    reset = 1'b1; p_req = '0;
    @(posedge clk50); #1;
    reset = 1'b0;
    tests++;
    if (mem_req !== 1'b0 || grant !== 2'b00 || p_rvalid !== 2'b00) begin
      fails++;
      $display("FAIL rst_rdwait: mem_req=%b grant=%b p_rvalid=%b, required 0 / 00 / 00", mem_req, grant, p_rvalid);
    end
    mem_rvalid = 1'b1; mem_rdata = 16'h5555;
    #1;
    tests++;
    if (p_rvalid !== 2'b00 || p_rdata !== 16'h0) begin
      fails++;
      $display("FAIL rst_late_rvalid: p_rvalid=%b p_rdata=%h, required 00 / 0000", p_rvalid, p_rdata);
    end
    @(posedge clk50); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    rd_pend = 1'b0;
    tests++;
    if (grant !== 2'b00 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_after: grant=%b mem_req=%b, required 00 / 0", grant, mem_req);
    end
    #1;
  endtask

  initial begin
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    do_reset();
    test_reset();
    test_write();
    test_read();
    test_stray_rvalid();
    test_abandon();
    test_round_robin();
    test_boot_lock();
    test_timeout();
    test_reset_in_rd_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
